// File: rtl/exe_arbiter.sv
// exe_arbiter: round-robin sequencer sharing one execution unit between two requesters.
// Define EXE_ARB_STATS_EN to build the saturating per-requester completion counters.
module exe_arbiter #(
    parameter int unsigned BITS    = 32,
    parameter int unsigned OPW     = 3,
    parameter int unsigned NUM_OPS = 6,
    parameter int unsigned ALU_LAT = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req0_valid,
    output logic            o_req0_ready,
    input  logic [OPW-1:0]  i_req0_op,
    input  logic [BITS-1:0] i_req0_argA,
    input  logic [BITS-1:0] i_req0_argB,
    input  logic            i_req1_valid,
    output logic            o_req1_ready,
    input  logic [OPW-1:0]  i_req1_op,
    input  logic [BITS-1:0] i_req1_argA,
    input  logic [BITS-1:0] i_req1_argB,
    output logic [OPW-1:0]  o_alu_op,
    output logic [BITS-1:0] o_alu_argA,
    output logic [BITS-1:0] o_alu_argB,
    input  logic [BITS-1:0] i_alu_result,
    input  logic            i_alu_error,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [BITS-1:0] o_rsp_result,
    output logic            o_rsp_error,
    output logic            o_rsp_id,
    output logic [15:0]     o_cnt0,
    output logic [15:0]     o_cnt1
);
    localparam int unsigned CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic            r_ptr;
    logic [CW-1:0]   r_wait;
    logic [OPW-1:0]  r_alu_op;
    logic [BITS-1:0] r_alu_a;
    logic [BITS-1:0] r_alu_b;
    logic            r_id;
    logic [BITS-1:0] r_rsp_result;
    logic            r_rsp_error;

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_grant;
    logic            w_legal;
    logic [OPW-1:0]  w_sel_op;
    logic [BITS-1:0] w_sel_a;
    logic [BITS-1:0] w_sel_b;

    // Grants only in IDLE; the pointer breaks ties when both requesters are valid.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!i_rst && r_state == StIdle) begin
            w_gnt0 = i_req0_valid && (!i_req1_valid || !r_ptr);
            w_gnt1 = i_req1_valid && (!i_req0_valid || r_ptr);
        end
    end

    assign w_grant  = w_gnt0 | w_gnt1;
    assign w_sel_op = w_gnt1 ? i_req1_op   : i_req0_op;
    assign w_sel_a  = w_gnt1 ? i_req1_argA : i_req0_argA;
    assign w_sel_b  = w_gnt1 ? i_req1_argB : i_req0_argB;
    assign w_legal  = (32'(w_sel_op) < NUM_OPS);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_grant) w_state_nxt = w_legal ? StExec : StResp;
            StExec:  if (r_wait == '0) w_state_nxt = StResp;
            StResp:  if (i_rsp_ready) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr        <= 1'b0;
            r_wait       <= '0;
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_id         <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_error  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_ptr    <= ~w_gnt1;
                r_id     <= w_gnt1;
                r_alu_op <= w_sel_op;
                r_alu_a  <= w_sel_a;
                r_alu_b  <= w_sel_b;
                r_wait   <= CW'(ALU_LAT);
                // Illegal ops bypass the unit and answer with an error immediately.
                if (!w_legal) begin
                    r_rsp_result <= '0;
                    r_rsp_error  <= 1'b1;
                end
            end
            if (r_state == StExec) begin
                if (r_wait == '0) begin
                    r_rsp_result <= i_alu_result;
                    r_rsp_error  <= i_alu_error;
                end else begin
                    r_wait <= r_wait - CW'(1);
                end
            end
        end
    end

    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;
    assign o_alu_op     = r_alu_op;
    assign o_alu_argA   = r_alu_a;
    assign o_alu_argB   = r_alu_b;
    assign o_rsp_valid  = (r_state == StResp);
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_error  = r_rsp_error;
    assign o_rsp_id     = r_id;

`ifdef EXE_ARB_STATS_EN
    logic        w_rsp_hs;
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    assign w_rsp_hs = o_rsp_valid && i_rsp_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_rsp_hs) begin
            if (!r_id && r_cnt0 != 16'hFFFF) r_cnt0 <= r_cnt0 + 16'd1;
            if (r_id && r_cnt1 != 16'hFFFF)  r_cnt1 <= r_cnt1 + 16'd1;
        end
    end

    assign o_cnt0 = r_cnt0;
    assign o_cnt1 = r_cnt1;
`else
    assign o_cnt0 = 16'h0;
    assign o_cnt1 = 16'h0;
`endif

endmodule

// File: tb/tb_exe_arbiter.sv
`timescale 1ns/1ps
// Bench for exe_arbiter: instances with ALU_LAT 0 and 3 checked every cycle against a
// transaction-level model, plus directed scenarios with literal expectations.
module tb_exe_arbiter;
    localparam int BITS    = 32;
    localparam int OPW     = 3;
    localparam int NUM_OPS = 6;
`ifdef EXE_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst     [2];
    logic            vld     [2][2];
    logic [OPW-1:0]  op      [2][2];
    logic [BITS-1:0] arg_a   [2][2];
    logic [BITS-1:0] arg_b   [2][2];
    logic            rspr    [2];
    logic            rdy     [2][2];
    logic [OPW-1:0]  alu_op  [2];
    logic [BITS-1:0] alu_a   [2];
    logic [BITS-1:0] alu_b   [2];
    logic [BITS-1:0] alu_res [2];
    logic            alu_err [2];
    logic            rsp_v   [2];
    logic [BITS-1:0] rsp_res [2];
    logic            rsp_err [2];
    logic            rsp_id  [2];
    logic [15:0]     cnt0    [2];
    logic [15:0]     cnt1    [2];

    // Shared-unit stand-in: op=1 A=0 B=5 gives 0x20; op 4 with B=0 flags an error.
    function automatic logic [BITS-1:0] alu_f(input logic [OPW-1:0] o, input logic [BITS-1:0] a,
                                              input logic [BITS-1:0] b);
        return a + b * ({29'd0, o} + 32'd1) + 32'd22;
    endfunction

    function automatic logic alu_e(input logic [OPW-1:0] o, input logic [BITS-1:0] b);
        return (o == 3'd4) && (b == '0);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_alu
        assign alu_res[g] = alu_f(alu_op[g], alu_a[g], alu_b[g]);
        assign alu_err[g] = alu_e(alu_op[g], alu_b[g]);
    end

    exe_arbiter #(.BITS(BITS), .OPW(OPW), .NUM_OPS(NUM_OPS), .ALU_LAT(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst[0]),
        .i_req0_valid(vld[0][0]), .o_req0_ready(rdy[0][0]), .i_req0_op(op[0][0]),
        .i_req0_argA(arg_a[0][0]), .i_req0_argB(arg_b[0][0]),
        .i_req1_valid(vld[0][1]), .o_req1_ready(rdy[0][1]), .i_req1_op(op[0][1]),
        .i_req1_argA(arg_a[0][1]), .i_req1_argB(arg_b[0][1]),
        .o_alu_op(alu_op[0]), .o_alu_argA(alu_a[0]), .o_alu_argB(alu_b[0]),
        .i_alu_result(alu_res[0]), .i_alu_error(alu_err[0]),
        .o_rsp_valid(rsp_v[0]), .i_rsp_ready(rspr[0]), .o_rsp_result(rsp_res[0]),
        .o_rsp_error(rsp_err[0]), .o_rsp_id(rsp_id[0]), .o_cnt0(cnt0[0]), .o_cnt1(cnt1[0])
    );

    exe_arbiter #(.BITS(BITS), .OPW(OPW), .NUM_OPS(NUM_OPS), .ALU_LAT(3)) u_dut1 (
        .i_clk(clk), .i_rst(rst[1]),
        .i_req0_valid(vld[1][0]), .o_req0_ready(rdy[1][0]), .i_req0_op(op[1][0]),
        .i_req0_argA(arg_a[1][0]), .i_req0_argB(arg_b[1][0]),
        .i_req1_valid(vld[1][1]), .o_req1_ready(rdy[1][1]), .i_req1_op(op[1][1]),
        .i_req1_argA(arg_a[1][1]), .i_req1_argB(arg_b[1][1]),
        .o_alu_op(alu_op[1]), .o_alu_argA(alu_a[1]), .o_alu_argB(alu_b[1]),
        .i_alu_result(alu_res[1]), .i_alu_error(alu_err[1]),
        .o_rsp_valid(rsp_v[1]), .i_rsp_ready(rspr[1]), .o_rsp_result(rsp_res[1]),
        .o_rsp_error(rsp_err[1]), .o_rsp_id(rsp_id[1]), .o_cnt0(cnt0[1]), .o_cnt1(cnt1[1])
    );

    // Transaction-level model: one command in flight, cycles remaining until its response shows.
    int              lat   [2] = '{0, 3};
    logic            m_busy[2];
    int              m_wait[2];
    logic            m_ptr [2];
    logic            m_id  [2];
    logic [BITS-1:0] m_res [2];
    logic            m_err [2];
    logic [OPW-1:0]  m_aop [2];
    logic [BITS-1:0] m_aa  [2];
    logic [BITS-1:0] m_ab  [2];
    int              m_c0  [2];
    int              m_c1  [2];
    logic [1:0]      m_gl  [2];

    int n_vec  = 0;
    int n_err  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_gnt(input int u);
        if (rst[u] || m_busy[u]) return 2'b00;
        if (vld[u][0] && vld[u][1]) return m_ptr[u] ? 2'b10 : 2'b01;
        return {vld[u][1], vld[u][0]};
    endfunction

    always @(posedge clk) begin : p_model
        logic [1:0] g;
        int r;
        for (int u = 0; u < 2; u++) begin
            g = exp_gnt(u);
            m_gl[u] = g;
            if (rst[u]) begin
                m_busy[u] = 1'b0; m_wait[u] = 0;   m_ptr[u] = 1'b0; m_id[u] = 1'b0;
                m_res[u]  = '0;   m_err[u]  = 1'b0; m_aop[u] = '0;  m_aa[u] = '0;
                m_ab[u]   = '0;   m_c0[u]   = 0;    m_c1[u]  = 0;
            end else if (m_busy[u]) begin
                if (m_wait[u] == 0) begin
                    if (rspr[u]) begin
                        m_busy[u] = 1'b0;
                        if (m_id[u]) m_c1[u] = (m_c1[u] == 65535) ? 65535 : m_c1[u] + 1;
                        else         m_c0[u] = (m_c0[u] == 65535) ? 65535 : m_c0[u] + 1;
                    end
                end else begin
                    m_wait[u]--;
                end
            end else if (g != 2'b00) begin
                r = g[1] ? 1 : 0;
                m_busy[u] = 1'b1;
                m_id[u]   = g[1];
                m_ptr[u]  = !g[1];
                m_aop[u]  = op[u][r];
                m_aa[u]   = arg_a[u][r];
                m_ab[u]   = arg_b[u][r];
                if (int'(op[u][r]) < NUM_OPS) begin
                    m_wait[u] = lat[u] + 1;
                    m_res[u]  = alu_f(op[u][r], arg_a[u][r], arg_b[u][r]);
                    m_err[u]  = alu_e(op[u][r], arg_b[u][r]);
                end else begin
                    m_wait[u] = 0;
                    m_res[u]  = '0;
                    m_err[u]  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin : p_cmp
        logic [1:0] g;
        logic ev;
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                g  = exp_gnt(u);
                ev = m_busy[u] && (m_wait[u] == 0);
                chk($sformatf("u%0d ready0", u), rdy[u][0], g[0]);
                chk($sformatf("u%0d ready1", u), rdy[u][1], g[1]);
                chk($sformatf("u%0d alu_op", u), alu_op[u], m_aop[u]);
                chk($sformatf("u%0d alu_a", u), alu_a[u], m_aa[u]);
                chk($sformatf("u%0d alu_b", u), alu_b[u], m_ab[u]);
                chk($sformatf("u%0d rsp_valid", u), rsp_v[u], ev);
                if (ev) begin
                    chk($sformatf("u%0d rsp_result", u), rsp_res[u], m_res[u]);
                    chk($sformatf("u%0d rsp_error", u), rsp_err[u], m_err[u]);
                    chk($sformatf("u%0d rsp_id", u), rsp_id[u], m_id[u]);
                end
                chk($sformatf("u%0d cnt0", u), cnt0[u], STATS ? 64'(m_c0[u]) : 64'd0);
                chk($sformatf("u%0d cnt1", u), cnt1[u], STATS ? 64'(m_c1[u]) : 64'd0);
            end
        end
    end

    task automatic nxt();
        @(posedge clk); #2;
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic new_args(input int u, input int r);
        op[u][r]    = 3'($urandom_range(0, 7));
        arg_a[u][r] = $urandom;
        arg_b[u][r] = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
    endtask

    task automatic do_cmd(input int u, input int r);
        int k;
        vld[u][r] = 1'b1;
        new_args(u, r);
        k = 0;
        smp();
        while (!rdy[u][r] && k < 20) begin nxt(); smp(); k++; end
        chk($sformatf("u%0d grant wait r%0d", u, r), rdy[u][r], 1'b1);
        nxt();
        vld[u][r] = 1'b0;
        k = 0;
        smp();
        while (!(rsp_v[u] && rspr[u]) && k < 20) begin nxt(); smp(); k++; end
        chk($sformatf("u%0d response wait", u), rsp_v[u], 1'b1);
        nxt();
    endtask

    initial begin : p_main
        int k;
        logic [BITS-1:0] held_res;
        logic held_id;
        int ids[$];

        for (int u = 0; u < 2; u++) begin
            rst[u]  = 1'b1;
            rspr[u] = 1'b1;
            for (int r = 0; r < 2; r++) begin
                vld[u][r] = 1'b1; op[u][r] = 3'(r); arg_a[u][r] = 32'h11; arg_b[u][r] = 32'h22;
            end
        end
        // Reset held two cycles with all valids high
        nxt();
        chk_en = 1'b1;
        smp();
        for (int u = 0; u < 2; u++) begin
            chk("reset ready0", rdy[u][0], 1'b0);
            chk("reset ready1", rdy[u][1], 1'b0);
            chk("reset rsp_valid", rsp_v[u], 1'b0);
            chk("reset alu_op", alu_op[u], 3'd0);
            chk("reset rsp_result", rsp_res[u], 32'd0);
        end
        nxt();
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b0;
            vld[u][1] = 1'b0;
            vld[u][0] = 1'b1; op[u][0] = 3'd1; arg_a[u][0] = 32'd0; arg_b[u][0] = 32'd5;
        end

        // Single legal command, ALU_LAT=0
        smp();
        chk("t2 ready0 at T", rdy[0][0], 1'b1);
        nxt();
        vld[0][0] = 1'b0; vld[1][0] = 1'b0;
        smp();
        chk("t2 rsp_valid at T+1", rsp_v[0], 1'b0);
        nxt(); smp();
        chk("t2 rsp_valid at T+2", rsp_v[0], 1'b1);
        chk("t2 rsp_result", rsp_res[0], 32'h20);
        chk("t2 rsp_error", rsp_err[0], 1'b0);
        chk("t2 rsp_id", rsp_id[0], 1'b0);
        nxt(); smp();
        chk("t2 idle at T+3", rsp_v[0], 1'b0);
        repeat (6) nxt();

        // Both requesters continuously valid from reset: grants alternate
        rst[0] = 1'b1; rst[1] = 1'b1;
        nxt();
        rst[0] = 1'b0; rst[1] = 1'b0;
        for (int u = 0; u < 2; u++) begin
            vld[u][0] = 1'b1; op[u][0] = 3'd2; arg_a[u][0] = 32'h100; arg_b[u][0] = 32'h7;
            vld[u][1] = 1'b1; op[u][1] = 3'd3; arg_a[u][1] = 32'h200; arg_b[u][1] = 32'h9;
        end
        for (int c = 0; c < 20; c++) begin
            smp();
            if (rsp_v[0] && rspr[0]) ids.push_back(int'(rsp_id[0]));
            nxt();
        end
        if (ids.size() < 4) chk("t3 response count", 64'(ids.size()), 64'd4);
        else for (int i = 0; i < 4; i++) chk($sformatf("t3 id%0d", i), 64'(ids[i]), 64'(i % 2));

        // Response backpressure
        rspr[0] = 1'b0;
        k = 0;
        smp();
        while (!rsp_v[0] && k < 10) begin nxt(); smp(); k++; end
        chk("t4 reach resp", rsp_v[0], 1'b1);
        held_res = rsp_res[0];
        held_id  = rsp_id[0];
        repeat (5) begin
            nxt(); smp();
            chk("t4 hold valid", rsp_v[0], 1'b1);
            chk("t4 hold result", rsp_res[0], held_res);
            chk("t4 hold id", rsp_id[0], held_id);
            chk("t4 no ready", {rdy[0][1], rdy[0][0]}, 2'b00);
        end
        nxt();
        rspr[0] = 1'b1;
        nxt(); smp();
        chk("t4 resume ready", rdy[0][0] | rdy[0][1], 1'b1);
        nxt();

        // Illegal opcode from requester 1
        for (int u = 0; u < 2; u++) begin vld[u][0] = 1'b0; vld[u][1] = 1'b0; end
        repeat (10) nxt();
        for (int u = 0; u < 2; u++) begin
            vld[u][1] = 1'b1; op[u][1] = 3'd7; arg_a[u][1] = $urandom; arg_b[u][1] = $urandom;
        end
        smp();
        chk("t5 ready1", rdy[0][1], 1'b1);
        nxt();
        vld[0][1] = 1'b0; vld[1][1] = 1'b0;
        smp();
        chk("t5 rsp_valid at T+1", rsp_v[0], 1'b1);
        chk("t5 rsp_result", rsp_res[0], 32'd0);
        chk("t5 rsp_error", rsp_err[0], 1'b1);
        chk("t5 rsp_id", rsp_id[0], 1'b1);
        repeat (4) nxt();

        // Reset in the second EXEC cycle of the ALU_LAT=3 instance drops the command
        vld[1][0] = 1'b1; op[1][0] = 3'd2; arg_a[1][0] = $urandom; arg_b[1][0] = $urandom;
        smp();
        chk("t6 ready0 at T", rdy[1][0], 1'b1);
        nxt();
        vld[1][0] = 1'b0;
        nxt();
        rst[1] = 1'b1;
        nxt();
        rst[1] = 1'b0;
        vld[1][1] = 1'b1; op[1][1] = 3'd0; arg_a[1][1] = 32'h5; arg_b[1][1] = 32'h6;
        smp();
        chk("t6 rsp_valid after reset", rsp_v[1], 1'b0);
        chk("t6 idle ready1", rdy[1][1], 1'b1);
        chk("t6 alu_op cleared", alu_op[1], 3'd0);
        nxt();
        vld[1][1] = 1'b0;
        nxt(); smp();
        chk("t6 no dropped response", rsp_v[1], 1'b0);
        repeat (8) nxt();

        // Completion counters: 3 from req0, 2 from req1 on each instance
        rst[0] = 1'b1; rst[1] = 1'b1;
        nxt();
        rst[0] = 1'b0; rst[1] = 1'b0;
        for (int u = 0; u < 2; u++) begin
            repeat (3) do_cmd(u, 0);
            repeat (2) do_cmd(u, 1);
            smp();
            chk("t7 cnt0", cnt0[u], STATS ? 16'd3 : 16'd0);
            chk("t7 cnt1", cnt1[u], STATS ? 16'd2 : 16'd0);
            nxt();
        end

        // Randomised traffic with backpressure bursts and occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int u = 0; u < 2; u++) begin
                for (int r = 0; r < 2; r++) begin
                    if (vld[u][r]) begin
                        if (m_gl[u][r]) begin
                            vld[u][r] = 1'($urandom_range(0, 1));
                            if (vld[u][r]) new_args(u, r);
                        end
                    end else if ($urandom_range(0, 2) == 0) begin
                        vld[u][r] = 1'b1;
                        new_args(u, r);
                    end
                end
                rspr[u] = ($urandom_range(0, 9) < ((c % 200 < 40) ? 1 : 7));
                rst[u]  = ($urandom_range(0, 499) == 0);
            end
            nxt();
        end
        smp();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
